// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of data_memory: port 0 is the core
// load/store path, port 1 a debug/DMA master that may lock memory for atomics.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [2:0]        m0_rw_type,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [2:0]        m1_rw_type,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              W_en,
  output logic              R_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2:0]        RW_type,
  output logic [DATA_W-1:0] Wr_mem_data,
  input  logic [DATA_W-1:0] Rd_mem_data
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                m0_rvalid_q, m0_rvalid_d;
  logic                m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
  logic                gnt0, gnt1;

  // Grants are forced low during reset so an access in the reset cycle never reaches memory.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        LOCKED:  gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    W_en        = 1'b0;
    R_en        = 1'b0;
    ram_addr    = '0;
    RW_type     = '0;
    Wr_mem_data = '0;
    if (gnt0) begin
      W_en        = m0_we;
      R_en        = ~m0_we;
      ram_addr    = m0_addr;
      RW_type     = m0_rw_type;
      Wr_mem_data = m0_wdata;
    end else if (gnt1) begin
      W_en        = m1_we;
      R_en        = ~m1_we;
      ram_addr    = m1_addr;
      RW_type     = m1_rw_type;
      Wr_mem_data = m1_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    m0_rvalid_d = gnt0 & ~m0_we;
    m1_rvalid_d = gnt1 & ~m1_we;
    m0_rdata_d  = m0_rvalid_d ? Rd_mem_data : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? Rd_mem_data : m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt0) last_d = 1'b0;
        if (gnt1) begin
          last_d = 1'b1;
          if (m1_lock) state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Leaving the lock hands priority to port 0, which has been starved.
        last_d = 1'b1;
        if (!m1_lock) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter; memory model returns ram_addr + 1 on reads.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0]  m0_rw_type;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0]  m1_rw_type;
  logic        W_en, R_en;
  logic [31:0] ram_addr, Wr_mem_data, Rd_mem_data;
  logic [2:0]  RW_type;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign Rd_mem_data = ram_addr + 32'd1;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_rw_type(m0_rw_type),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_rw_type(m1_rw_type), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .W_en(W_en), .R_en(R_en), .ram_addr(ram_addr), .RW_type(RW_type),
    .Wr_mem_data(Wr_mem_data), .Rd_mem_data(Rd_mem_data)
  );

  typedef struct {
    logic        rst_n;
    logic        r0, we0;
    logic [31:0] a0;
    logic [2:0]  t0;
    logic [31:0] d0;
    logic        r1, we1, lk;
    logic [31:0] a1;
    logic [2:0]  t1;
    logic [31:0] d1;
    logic        g0, g1, v0, v1;
    logic [31:0] q0, q1;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] RD0 = 32'hA0A0A0A0;
  localparam logic [31:0] RD1 = 32'hB1B1B1B1;

  // loser-hold bookkeeping from the previous vector
  logic        pend0, pend1;
  vec_t        prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic rs,
      input logic r0, input logic we0, input logic [31:0] a0, input logic [2:0] t0, input logic [31:0] d0,
      input logic r1, input logic we1, input logic lk, input logic [31:0] a1, input logic [2:0] t1,
      input logic [31:0] d1,
      input logic g0, input logic g1, input logic v0, input logic v1,
      input logic [31:0] q0, input logic [31:0] q1);
    vec_t v;
    v.rst_n = rs; v.r0 = r0; v.we0 = we0; v.a0 = a0; v.t0 = t0; v.d0 = d0;
    v.r1 = r1; v.we1 = we1; v.lk = lk; v.a1 = a1; v.t1 = t1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    logic        ew, er;
    logic [31:0] ea, ed;
    logic [2:0]  et;
    @(negedge clk);
    rst_n = v.rst_n;
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_rw_type = v.t0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.we1; m1_lock = v.lk; m1_addr = v.a1; m1_rw_type = v.t1;
    m1_wdata = v.d1;
    #1;
    if (pend0) begin
      n_checks++;
      if (!(m0_req && m0_we == prev.we0 && m0_addr == prev.a0 && m0_rw_type == prev.t0
            && m0_wdata == prev.d0)) begin
        n_fail++;
        $display("FAIL %s hold0: port 0 dropped or changed an ungranted request", tag);
      end
    end
    if (pend1) begin
      n_checks++;
      if (!(m1_req && m1_we == prev.we1 && m1_addr == prev.a1 && m1_rw_type == prev.t1
            && m1_wdata == prev.d1)) begin
        n_fail++;
        $display("FAIL %s hold1: port 1 dropped or changed an ungranted request", tag);
      end
    end
    {ew, er, ea, et, ed} = '0;
    if (v.g0) begin
      ew = v.we0; er = ~v.we0; ea = v.a0; et = v.t0; ed = v.d0;
    end else if (v.g1) begin
      ew = v.we1; er = ~v.we1; ea = v.a1; et = v.t1; ed = v.d1;
    end
    chk({tag, " m0_gnt"},      32'(m0_gnt),    32'(v.g0));
    chk({tag, " m1_gnt"},      32'(m1_gnt),    32'(v.g1));
    chk({tag, " W_en"},        32'(W_en),      32'(ew));
    chk({tag, " R_en"},        32'(R_en),      32'(er));
    chk({tag, " ram_addr"},    ram_addr,       ea);
    chk({tag, " RW_type"},     32'(RW_type),   32'(et));
    chk({tag, " Wr_mem_data"}, Wr_mem_data,    ed);
    chk({tag, " m0_rvalid"},   32'(m0_rvalid), 32'(v.v0));
    chk({tag, " m1_rvalid"},   32'(m1_rvalid), 32'(v.v1));
    chk({tag, " m0_rdata"},    m0_rdata,       v.q0);
    chk({tag, " m1_rdata"},    m1_rdata,       v.q1);
    pend0 = v.rst_n && v.r0 && !v.g0;
    pend1 = v.rst_n && v.r1 && !v.g1;
    prev  = v;
  endtask

  initial begin
    pend0 = 1'b0; pend1 = 1'b0;
    rst_n = 1'b0;
    {m0_req, m0_we, m1_req, m1_we, m1_lock} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
    m0_rw_type = '0; m1_rw_type = '0;
    repeat (2) @(posedge clk);

    // rst  r0 we0 a0  t0  d0   r1 we1 lk a1  t1  d1   g0 g1 v0 v1 q0  q1
    // reset with both requesting, then contention 0,1,0,1 and loser completion
    vecs.push_back(mk(0, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 0,0,0,0,32'h0, 32'h0));
    vecs.push_back(mk(0, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 0,0,0,0,32'h0, 32'h0));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 1,0,0,0,32'h0, 32'h0));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 0,1,1,0,32'h11,32'h0));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 1,0,0,1,32'h11,32'h21));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 0,1,1,0,32'h11,32'h21));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 0,0,0,32'h0, 3'b000,32'h0, 1,0,0,1,32'h11,32'h21));
    // port 1 back-to-back writes, port 0 idle
    vecs.push_back(mk(1, 0,0,32'h0, 3'b000,32'h0, 1,1,0,32'h100,3'b010,32'hDEADBEEF, 0,1,1,0,32'h11,32'h21));
    vecs.push_back(mk(1, 0,0,32'h0, 3'b000,32'h0, 1,1,0,32'h100,3'b010,32'hDEADBEEF, 0,1,0,0,32'h11,32'h21));
    vecs.push_back(mk(1, 0,0,32'h0, 3'b000,32'h0, 1,1,0,32'h100,3'b010,32'hDEADBEEF, 0,1,0,0,32'h11,32'h21));
    // lock sequence: m0 starved while locked, wins right after release
    vecs.push_back(mk(1, 1,0,32'h2C,3'b010,RD0, 0,0,0,32'h0, 3'b000,32'h0, 1,0,0,0,32'h11,32'h21));
    vecs.push_back(mk(1, 1,0,32'h30,3'b010,RD0, 1,1,1,32'h200,3'b001,32'h12345678, 0,1,1,0,32'h2D,32'h21));
    vecs.push_back(mk(1, 1,0,32'h30,3'b010,RD0, 1,0,1,32'h40,3'b100,RD1, 0,1,0,0,32'h2D,32'h21));
    vecs.push_back(mk(1, 1,0,32'h30,3'b010,RD0, 1,1,1,32'h44,3'b010,32'hCAFEF00D, 0,1,0,1,32'h2D,32'h41));
    vecs.push_back(mk(1, 1,0,32'h30,3'b010,RD0, 0,0,0,32'h0, 3'b000,32'h0, 0,0,0,0,32'h2D,32'h41));
    vecs.push_back(mk(1, 1,0,32'h30,3'b010,RD0, 0,0,0,32'h0, 3'b000,32'h0, 1,0,0,0,32'h2D,32'h41));
    // lock again with a read, then reset while locked with a pending read
    vecs.push_back(mk(1, 0,0,32'h0, 3'b000,32'h0, 1,0,1,32'h60,3'b101,RD1, 0,1,1,0,32'h31,32'h41));
    vecs.push_back(mk(0, 1,0,32'h30,3'b010,RD0, 1,0,1,32'h70,3'b101,RD1, 0,0,0,1,32'h31,32'h61));
    vecs.push_back(mk(1, 1,0,32'h30,3'b010,RD0, 1,0,0,32'h70,3'b101,RD1, 1,0,0,0,32'h0, 32'h0));
    vecs.push_back(mk(1, 0,0,32'h0, 3'b000,32'h0, 1,0,0,32'h70,3'b101,RD1, 0,1,1,0,32'h31,32'h0));
    // five idle cycles: rdata holds, last preserved
    vecs.push_back(mk(1, 0,0,32'h0, 3'b000,32'h0, 0,0,0,32'h0, 3'b000,32'h0, 0,0,0,1,32'h31,32'h71));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0,0,32'h0, 3'b000,32'h0, 0,0,0,32'h0, 3'b000,32'h0, 0,0,0,0,32'h31,32'h71));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 1,0,0,0,32'h31,32'h71));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 1,0,0,32'h20,3'b101,RD1, 0,1,1,0,32'h11,32'h71));
    vecs.push_back(mk(1, 1,0,32'h10,3'b010,RD0, 0,0,0,32'h0, 3'b000,32'h0, 1,0,0,1,32'h11,32'h21));

    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    // release with a port-1 access in the release cycle, then port 0 gets priority
    run_vec("lk_set", mk(1, 0,0,32'h0, 3'b000,32'h0, 1,0,1,32'h80,3'b101,RD1, 0,1,1,0,32'h11,32'h21));
    run_vec("lk_rel", mk(1, 1,0,32'h90,3'b010,RD0, 1,0,0,32'h84,3'b101,RD1, 0,1,0,1,32'h11,32'h81));
    run_vec("lk_p0",  mk(1, 1,0,32'h90,3'b010,RD0, 0,0,0,32'h0, 3'b000,32'h0, 1,0,0,1,32'h11,32'h85));
    // write in a reset cycle is dropped and read state clears
    run_vec("rst_wr", mk(0, 1,1,32'h98,3'b000,32'h55, 0,0,0,32'h0, 3'b000,32'h0, 0,0,1,0,32'h91,32'h85));
    run_vec("rst_ok", mk(1, 0,0,32'h0, 3'b000,32'h0, 0,0,0,32'h0, 3'b000,32'h0, 0,0,0,0,32'h0, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
